// File: rtl/jtframe_ram_dma_pkg.sv
// jtframe_ram_dma_pkg
// Shared definitions for the RAM-to-RAM DMA engine: state encodings and the
// state type used by the controller FSM.
package jtframe_ram_dma_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_RUN   = RUN,
        ST_DRAIN = DRAIN,
        ST_DONE  = DONE
    } dma_state_t;

endpackage

// File: rtl/jtframe_ram_dma.sv
// jtframe_ram_dma
// Copies len words from a source RAM to a destination RAM, or fills the
// destination with a constant. Designed to sit next to a dual-port RAM whose
// read port has one cen cycle of latency and shares this block's cen.
//
// Optional feature: define JTFRAME_RAM_DMA_CHKSUM_EN to add the chksum output
// (modulo-2**DW sum of every word written by the current transfer).
//
// Ports
//   rst        async active-high reset
//   clk        clock; state advances on rising edges with cen=1
//   cen        clock enable shared with the attached RAMs
//   start      transfer request, sampled only while idle
//   fill       0 = copy, 1 = write fill_data
//   src_addr   first source address
//   dst_addr   first destination address
//   len        word count, 0 .. 2**AW
//   fill_data  fill value
//   busy       transfer in progress (RUN, DRAIN, DONE)
//   done       one-cycle pulse at end of transfer
//   rd_addr    source RAM read address
//   rd_q       source RAM read data, one cen cycle after rd_addr
//   wr_addr    destination write address
//   wr_data    destination write data
//   wr_we      destination write strobe
//   chksum     (optional) sum of written words, valid while done=1
module jtframe_ram_dma
    import jtframe_ram_dma_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          start,
    input  logic          fill,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_q,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_we
`ifdef JTFRAME_RAM_DMA_CHKSUM_EN
    ,
    output logic [DW-1:0] chksum
`endif
);

    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_ZERO = 0;

    dma_state_t    r_state;
    dma_state_t    w_next;

    logic [AW:0]   r_cnt;        // reads still to issue, including current
    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_dst;        // destination of the read issued this cycle
    logic [AW-1:0] r_wr_addr;
    logic          r_wr_we;
    logic          r_fill;
    logic [DW-1:0] r_fill_data;
    logic          w_last_issue;
    logic [DW-1:0] w_wr_data;

    assign w_last_issue = (r_cnt == CNT_ONE);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (cen) begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = (len != CNT_ZERO) ? ST_RUN : ST_DONE;
            ST_RUN:   if (w_last_issue) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ---------------- address / write pipeline ----------------
    // Each RUN cycle issues one read; the matching write is registered so it
    // appears in the following cen cycle, exactly when the RAM presents rd_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rd_addr   <= '0;
            r_dst       <= '0;
            r_wr_addr   <= '0;
            r_wr_we     <= 1'b0;
            r_fill      <= 1'b0;
            r_fill_data <= '0;
        end else if (cen) begin
            r_wr_we <= (r_state == ST_RUN);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rd_addr   <= src_addr;
                        r_dst       <= dst_addr;
                        r_cnt       <= len;
                        r_fill      <= fill;
                        r_fill_data <= fill_data;
                    end
                end
                ST_RUN: begin
                    r_rd_addr <= r_rd_addr + ADDR_ONE;
                    r_cnt     <= r_cnt - CNT_ONE;
                    r_wr_addr <= r_dst;
                    r_dst     <= r_dst + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    // rd_q is only meaningful during a write cycle; gating keeps wr_data at
    // zero whenever no write is pending (including reset).
    assign w_wr_data = r_wr_we ? (r_fill ? r_fill_data : rd_q) : '0;

`ifdef JTFRAME_RAM_DMA_CHKSUM_EN
    logic [DW-1:0] r_chksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chksum <= '0;
        end else if (cen) begin
            if (r_state == ST_IDLE && start) begin
                r_chksum <= '0;
            end else if (r_wr_we) begin
                r_chksum <= r_chksum + w_wr_data;
            end
        end
    end

    assign chksum = r_chksum;
`endif

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign rd_addr = r_rd_addr;
    assign wr_addr = r_wr_addr;
    assign wr_data = w_wr_data;
    assign wr_we   = r_wr_we;

endmodule

// File: tb/tb_jtframe_ram_dma.sv
module tb_jtframe_ram_dma;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b0;
    logic          start = 1'b0;
    logic          fill = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_data = '0;
    logic          busy, done, wr_we;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_q;
`ifdef JTFRAME_RAM_DMA_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    logic [DW-1:0] src_mem [N];
    logic [DW-1:0] dst_mem [N];
    logic [DW-1:0] exp_mem [N];
    logic          clr = 1'b1;
    int            wr_total = 0;
    int            checks = 0;
    int            errors = 0;

    jtframe_ram_dma #(.AW(AW), .DW(DW)) dut (
        .rst(rst), .clk(clk), .cen(cen), .start(start), .fill(fill),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_q(rd_q), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_we(wr_we)
`ifdef JTFRAME_RAM_DMA_CHKSUM_EN
        , .chksum(chksum)
`endif
    );

    always #5 clk = ~clk;

    // Source RAM read port and destination RAM write port, both sharing cen.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < N; i++) dst_mem[i] <= '0;
            rd_q <= '0;
        end else if (cen) begin
            rd_q <= src_mem[rd_addr];
            if (wr_we) begin
                dst_mem[wr_addr] <= wr_data;
                wr_total <= wr_total + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff();
        for (int i = 0; i < N; i++)
            if (dst_mem[i] !== exp_mem[i]) return i;
        return -1;
    endfunction

    // One complete transfer checked against the plain "dst[d+k] = value" rule.
    task automatic do_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] l, input logic f,
                           input logic [DW-1:0] fd, input int cmode,
                           input bit poke, input string tag);
        int base, e, budget, want_cyc, diff;
        logic [AW-1:0] idx;
        logic [DW-1:0] sum;
        base = wr_total;
        sum = '0;
        for (int k = 0; k < int'(l); k++) begin
            idx = AW'(int'(d) + k);
            exp_mem[idx] = f ? fd : src_mem[AW'(int'(s) + k)];
            sum = sum + exp_mem[idx];
        end
        src_addr = s; dst_addr = d; len = l; fill = f; fill_data = fd;
        start = 1'b1; cen = 1'b1;
        tick();
        start = 1'b0;
        // Scramble inputs so anything not latched at start shows up as an error
        src_addr = AW'($urandom); dst_addr = AW'($urandom);
        len = (AW+1)'($urandom); fill = ~f; fill_data = DW'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start got %b want 1", tag, busy);
        end
        e = 1; budget = 0;
        while (done !== 1'b1 && budget < 4*N + 100) begin
            case (cmode)
                0: cen = 1'b1;
                1: cen = ~cen;
                default: cen = 1'($urandom_range(0, 1));
            endcase
            start = (poke && e == 3) ? 1'b1 : 1'b0;
            tick();
            if (cen) e++;
            budget++;
        end
        start = 1'b0;
        want_cyc = (l == 0) ? 1 : int'(l) + 2;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL %s done_timeout got %b want 1", tag, done);
        end
        checks++;
        if (e != want_cyc) begin
            errors++; $display("FAIL %s cycles got %0d want %0d", tag, e, want_cyc);
        end
`ifdef JTFRAME_RAM_DMA_CHKSUM_EN
        checks++;
        if (chksum !== sum) begin
            errors++; $display("FAIL %s chksum got %h want %h", tag, chksum, sum);
        end
`endif
        checks++;
        if (wr_total - base != int'(l)) begin
            errors++; $display("FAIL %s writes got %0d want %0d", tag, wr_total - base, l);
        end
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL %s mem[%0h] got %h want %h", tag, diff, dst_mem[diff], exp_mem[diff]);
        end
        cen = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse got %b want 0", tag, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s idle_after got %b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b1; start = 1'b1; len = 11'd5;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (wr_we !== 1'b0) begin errors++; $display("FAIL rst_wr_we got %b want 0", wr_we); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL rst_rd_addr got %h want 0", rd_addr); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL rst_wr_addr got %h want 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
        start = 1'b0; clr = 1'b0;
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
    endtask

    task automatic test_copy();
        for (int i = 0; i < 4; i++) src_mem[10'h010 + i] = DW'(8'hA1 + i);
        do_xfer(10'h010, 10'h200, 11'd4, 1'b0, 8'h00, 0, 1'b0, "copy4");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dst_mem[10'h200 + i] !== DW'(8'hA1 + i)) begin
                errors++;
                $display("FAIL copy4_word%0d got %h want %h", i, dst_mem[10'h200 + i], 8'hA1 + i);
            end
        end
    endtask

    task automatic test_fill_wrap();
        logic [AW-1:0] a;
        do_xfer(10'h155, 10'h3FE, 11'd4, 1'b1, 8'h5A, 0, 1'b0, "fill_wrap");
        for (int i = 0; i < 4; i++) begin
            a = AW'(10'h3FE + i);
            checks++;
            if (dst_mem[a] !== 8'h5A) begin
                errors++; $display("FAIL fill_wrap_%0h got %h want 5a", a, dst_mem[a]);
            end
        end
    endtask

    task automatic test_len0();
        do_xfer(10'h020, 10'h100, 11'd0, 1'b0, 8'h00, 0, 1'b0, "len0");
    endtask

    task automatic test_cen_toggle();
        do_xfer(10'h040, 10'h240, 11'd8, 1'b0, 8'h00, 1, 1'b0, "cen_toggle");
    endtask

    task automatic test_start_while_busy();
        do_xfer(10'h060, 10'h2A0, 11'd8, 1'b0, 8'h00, 0, 1'b1, "start_busy");
    endtask

    task automatic test_reset_mid();
        int base, budget;
        base = wr_total;
        src_addr = 10'h100; dst_addr = 10'h300; len = 11'd16; fill = 1'b0;
        start = 1'b1; cen = 1'b1;
        tick();
        start = 1'b0;
        budget = 0;
        while (wr_total - base < 3 && budget < 100) begin
            tick(); budget++;
        end
        checks++;
        if (wr_total - base != 3) begin
            errors++; $display("FAIL rst_mid_reach3 got %0d want 3", wr_total - base);
        end
        for (int k = 0; k < 3; k++) exp_mem[AW'(10'h300 + k)] = src_mem[AW'(10'h100 + k)];
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || wr_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async busy %b wr_we %b want 0 0", busy, wr_we);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (wr_total - base != 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet writes %0d busy %b want 3 0", wr_total - base, busy);
        end
        do_xfer(10'h180, 10'h320, 11'd5, 1'b0, 8'h00, 0, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        logic [AW-1:0] s, d;
        logic [AW:0]   l;
        for (int t = 0; t < 12; t++) begin
            s = AW'($urandom); d = AW'($urandom);
            l = (AW+1)'($urandom_range(0, 40));
            do_xfer(s, d, l, 1'($urandom_range(0, 1)), DW'($urandom), 2, 1'b0, "random");
        end
        do_xfer(AW'($urandom), AW'($urandom), (AW+1)'(N), 1'b0, 8'h00, 0, 1'b0, "full_mem");
    endtask

    task automatic test_chksum();
`ifdef JTFRAME_RAM_DMA_CHKSUM_EN
        do_xfer(10'h000, 10'h050, 11'd3, 1'b1, 8'h80, 0, 1'b0, "chksum_fill");
        checks++;
        if (chksum !== 8'h80) begin
            errors++; $display("FAIL chksum_fill_const got %h want 80", chksum);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_mem[i] = DW'($urandom);
            exp_mem[i] = '0;
        end
        test_reset();
        test_copy();
        test_fill_wrap();
        test_len0();
        test_cen_toggle();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        test_chksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
